mem_req_ctrl: RTL and testbench

- Request/response front-end that sits directly upstream of the single-port synchronous memory.
- Accepts read/write requests on a valid/ready handshake and drives the memory's address, data_input, read and write pins.
- Captures the memory's registered data_output one cycle after a read and returns it in order through a response FIFO with valid/ready backpressure.
- Never asserts memory read and write together.

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/mem_req_ctrl_if.sv | 33 +++
 rtl/mem_rsp_fifo.sv | 55 +++++
 rtl/mem_req_ctrl.sv | 101 ++++++++++
 tb/tb_mem_req_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants and helpers for the memory request controller.
// MEM_WRITE_ACK_EN adds a write-ack flag bit to each response entry.
package mem_ctrl_pkg;

    localparam int A_SIZE_DEF = 10;
    localparam int D_SIZE_DEF = 32;

`ifdef MEM_WRITE_ACK_EN
    localparam int ACK_W = 1;
`else
    localparam int ACK_W = 0;
`endif

    // Response entry: data, plus an is_write flag on top when write acks exist
    localparam int RSP_W = D_SIZE_DEF + ACK_W;

    // Ceiling log2, used for FIFO pointer widths
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request, response and memory-pin bundle of the memory request controller.
// master = requester/memory side, slave = controller.
interface mem_req_ctrl_if #(
    parameter int A_SIZE = mem_ctrl_pkg::A_SIZE_DEF,
    parameter int D_SIZE = mem_ctrl_pkg::D_SIZE_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [A_SIZE-1:0] req_addr;
    logic [D_SIZE-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [D_SIZE-1:0] rsp_data;
    logic              rsp_is_write;
    logic [A_SIZE-1:0] mem_address;
    logic [D_SIZE-1:0] mem_data_out;
    logic              mem_read;
    logic              mem_write;
    logic [D_SIZE-1:0] mem_data_in;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_in,
        input  req_ready, rsp_valid, rsp_data, rsp_is_write,
        input  mem_address, mem_data_out, mem_read, mem_write
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_in,
        output req_ready, rsp_valid, rsp_data, rsp_is_write,
        output mem_address, mem_data_out, mem_read, mem_write
    );
endinterface

// File: rtl/mem_rsp_fifo.sv
// First-word-fall-through response FIFO. Only pointers and count are reset;
// storage keeps whatever it last held.
module mem_rsp_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    // Storage write; no reset so it maps onto plain distributed memory
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request/response front-end for a single-port synchronous memory.
// Optional MEM_WRITE_ACK_EN: writes also return an ack response entry.
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int A_SIZE    = A_SIZE_DEF,
    parameter int D_SIZE    = D_SIZE_DEF,
    parameter int RSP_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_req_ctrl_if.slave bus
);
    localparam int PW = clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int W  = D_SIZE + ACK_W;

    logic              fire;
    logic              pend_set;
    logic              rd_pend;
    logic [CW-1:0]     count;
    logic [CW-1:0]     occupancy;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [W-1:0]      push_data;
    logic [W-1:0]      head;
    logic [A_SIZE-1:0] addr;
    logic [D_SIZE-1:0] wdata;

    // Space is reserved for the entry still in flight; pops are not credited
    // so rsp_ready never reaches req_ready combinationally.
    assign occupancy     = count + CW'(rd_pend);
    assign bus.req_ready = !rst && (occupancy < CW'(RSP_DEPTH));
    assign fire          = bus.req_valid && bus.req_ready;

    assign addr             = bus.req_addr;
    assign wdata            = bus.req_wdata;
    assign bus.mem_address  = addr;
    assign bus.mem_data_out = wdata;
    assign bus.mem_read     = fire && !bus.req_write;
    assign bus.mem_write    = fire && bus.req_write;

`ifdef MEM_WRITE_ACK_EN
    logic              pend_is_write;
    logic [D_SIZE-1:0] pend_wdata;

    assign pend_set  = fire;
    assign push_data = pend_is_write ? {1'b1, pend_wdata} : {1'b0, bus.mem_data_in};

    // Remember what kind of entry the in-flight slot will become
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_is_write <= 1'b0;
            pend_wdata    <= '0;
        end else if (fire) begin
            pend_is_write <= bus.req_write;
            pend_wdata    <= bus.req_wdata;
        end
    end

    assign bus.rsp_is_write = bus.rsp_valid && head[D_SIZE];
`else
    assign pend_set         = fire && !bus.req_write;
    assign push_data        = bus.mem_data_in;
    assign bus.rsp_is_write = 1'b0;
`endif

    // In-flight flag: memory output is valid exactly one edge after the fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= pend_set;
        end
    end

    // Occupancy accounting makes a full-FIFO push unreachable; the guard is defensive
    assign push = rd_pend && !(fifo_full && !pop);
    assign pop  = bus.rsp_valid && bus.rsp_ready;

    mem_rsp_fifo #(
        .WIDTH (W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_data  = head[D_SIZE-1:0];

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Table-driven bench for mem_req_ctrl with a behavioural single-port memory.
module tb_mem_req_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_req_ctrl_if #(.A_SIZE(AW), .D_SIZE(DW)) bus ();

    mem_req_ctrl #(
        .A_SIZE    (AW),
        .D_SIZE    (DW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: registered read, output holds while read is low
    logic [DW-1:0] mem_arr [0:1023];
    logic [DW-1:0] mem_dout;
    always @(posedge clk) begin
        if (bus.mem_write) mem_arr[bus.mem_address] <= bus.mem_data_out;
        if (bus.mem_read)  mem_dout <= mem_arr[bus.mem_address];
    end
    assign bus.mem_data_in = mem_dout;

    typedef struct {
        logic          v;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          rr;
        logic          e_rdy;
        logic          e_rv;
        logic [DW-1:0] e_data;
        logic          e_mr;
        logic          e_mw;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input int v, input int w, input int a, input logic [DW-1:0] d,
                                input int rr, input int rdy, input int rv,
                                input logic [DW-1:0] ed, input int mr, input int mw);
        vec_t t;
        t.v = (v != 0);   t.w = (w != 0);   t.a = AW'(a);   t.d = d;
        t.rr = (rr != 0); t.e_rdy = (rdy != 0); t.e_rv = (rv != 0);
        t.e_data = ed;    t.e_mr = (mr != 0); t.e_mw = (mw != 0);
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input int a, input logic [DW-1:0] d, input logic rr);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = AW'(a);
        bus.req_wdata = d;
        bus.rsp_ready = rr;
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_strobes(input string tag);
        chk({tag, " strobe_overlap"}, 32'(bus.mem_read && bus.mem_write), 32'd0);
    endtask

    // Single write followed by idle cycles so any ack drains
    task automatic do_write(input int a, input logic [DW-1:0] d);
        drive(1'b1, 1'b1, a, d, 1'b1);
        step();
        drive(1'b0, 1'b0, 0, 32'd0, 1'b1);
        repeat (4) step();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        drive(1'b1, 1'b0, 0, 32'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        // Reset state: everything quiet even with a request offered
        @(negedge clk);
        chk("reset req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_is_write", 32'(bus.rsp_is_write), 32'd0);
        chk("reset mem_read", 32'(bus.mem_read), 32'd0);
        drive(1'b0, 1'b0, 0, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifndef MEM_WRITE_ACK_EN
        // Write then read back, latency two cycles after the read handshake
        add(1,1,5,32'hDEADBEEF,1, 1,0,32'd0,0,1);
        add(1,0,5,32'd0,1,        1,0,32'd0,1,0);
        add(0,0,0,32'd0,1,        1,0,32'd0,0,0);
        add(0,0,0,32'd0,1,        1,1,32'hDEADBEEF,0,0);
        add(0,0,0,32'd0,1,        1,0,32'd0,0,0);
        // Preload addr i = 3*i and addr 9 = 0x11
        for (int i = 0; i < 8; i++) add(1,1,i,32'(i*3),1, 1,0,32'd0,0,1);
        add(1,1,9,32'h11,1, 1,0,32'd0,0,1);
        // Streaming reads 0..7, one per cycle
        for (int k = 0; k < 8; k++) add(1,0,k,32'd0,1, 1,(k >= 2) ? 1 : 0,(k >= 2) ? 32'((k-2)*3) : 32'd0,1,0);
        add(0,0,0,32'd0,1, 1,1,32'd18,0,0);
        add(0,0,0,32'd0,1, 1,1,32'd21,0,0);
        add(0,0,0,32'd0,1, 1,0,32'd0,0,0);
        // Backpressure: only DEPTH reads are accepted
        for (int b = 0; b < 6; b++) add(1,0,b,32'd0,0, (b < 4) ? 1 : 0,(b >= 2) ? 1 : 0,32'd0,(b < 4) ? 1 : 0,0);
        add(0,0,0,32'd0,1, 0,1,32'd0,0,0);
        add(0,0,0,32'd0,1, 1,1,32'd3,0,0);
        add(0,0,0,32'd0,1, 1,1,32'd6,0,0);
        add(0,0,0,32'd0,1, 1,1,32'd9,0,0);
        add(0,0,0,32'd0,1, 1,0,32'd0,0,0);
        // Read-then-write hazard on addr 9
        add(1,0,9,32'd0,1,   1,0,32'd0,1,0);
        add(1,1,9,32'h22,1,  1,0,32'd0,0,1);
        add(1,0,9,32'd0,1,   1,1,32'h11,1,0);
        add(0,0,0,32'd0,1,   1,0,32'd0,0,0);
        add(0,0,0,32'd0,1,   1,1,32'h22,0,0);
        add(0,0,0,32'd0,1,   1,0,32'd0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].v, vecs[i].w, int'(vecs[i].a), vecs[i].d, vecs[i].rr);
            @(negedge clk);
            chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(vecs[i].e_rdy));
            chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(vecs[i].e_rv));
            chk({tag, " mem_read"},  32'(bus.mem_read),  32'(vecs[i].e_mr));
            chk({tag, " mem_write"}, 32'(bus.mem_write), 32'(vecs[i].e_mw));
            chk({tag, " rsp_is_write"}, 32'(bus.rsp_is_write), 32'd0);
            if (vecs[i].e_rv) chk({tag, " rsp_data"}, bus.rsp_data, vecs[i].e_data);
            chk_strobes(tag);
            $display("vec %0d: v=%0b w=%0b a=%0d rr=%0b -> rdy=%0b rv=%0b data=%h",
                     i, vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].rr,
                     bus.req_ready, bus.rsp_valid, bus.rsp_data);
            step();
        end
        drive(1'b0, 1'b0, 0, 32'd0, 1'b1);
        step();
`endif

        // Reset while a read is in flight
        do_write(20, 32'h12345678);
        drive(1'b1, 1'b0, 20, 32'd0, 1'b1);
        step();
        drive(1'b0, 1'b0, 0, 32'd0, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst req_ready", 32'(bus.req_ready), 32'd0);
        drive(1'b1, 1'b0, 20, 32'd0, 1'b1);
        #1;
        chk("midrst mem_read", 32'(bus.mem_read), 32'd0);
        drive(1'b1, 1'b1, 20, 32'hBAD0BAD0, 1'b1);
        #1;
        chk("midrst mem_write", 32'(bus.mem_write), 32'd0);
        drive(1'b0, 1'b0, 0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
            step();
        end
        $display("reset mid-read: no stale response observed");
        // Fresh read after reset, bounded wait for the response
        drive(1'b1, 1'b0, 20, 32'd0, 1'b1);
        n = 0;
        step();
        drive(1'b0, 1'b0, 0, 32'd0, 1'b1);
        n = 1;
        @(negedge clk);
        while (!bus.rsp_valid && n < 8) begin
            step();
            n++;
            @(negedge clk);
        end
        chk("fresh_read rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("fresh_read latency", 32'(n), 32'd2);
        chk("fresh_read rsp_data", bus.rsp_data, 32'h12345678);
        $display("fresh read addr 20: latency=%0d data=%h", n, bus.rsp_data);
        step();
        step();

        // Write ack behaviour
        drive(1'b1, 1'b1, 3, 32'hA5, 1'b1);
        @(negedge clk);
        chk("ack mem_write", 32'(bus.mem_write), 32'd1);
        chk("ack mem_read", 32'(bus.mem_read), 32'd0);
        step();
        drive(1'b0, 1'b0, 0, 32'd0, 1'b1);
        @(negedge clk);
        chk("ack t+1 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        @(negedge clk);
`ifdef MEM_WRITE_ACK_EN
        chk("ack t+2 rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("ack t+2 rsp_is_write", 32'(bus.rsp_is_write), 32'd1);
        chk("ack t+2 rsp_data", bus.rsp_data, 32'hA5);
`else
        chk("ack t+2 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("ack t+2 rsp_is_write", 32'(bus.rsp_is_write), 32'd0);
`endif
        $display("write 0xA5 to addr 3: t+2 rsp_valid=%0b is_write=%0b data=%h",
                 bus.rsp_valid, bus.rsp_is_write, bus.rsp_data);
        step();
        @(negedge clk);
        chk("ack t+3 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("ack t+3 rsp_is_write", 32'(bus.rsp_is_write), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
